// File: rtl/o_buft_ds_bank.sv
// Multi-channel controller for differential tri-state output pads: per-channel
// enable FSM with guard cycles, programmable data delay and a shared sticky fault.
module o_buft_ds_bank #(
  parameter int CHANNELS     = 4,
  parameter int GUARD_CYCLES = 2,
  parameter int DELAY        = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] en,
  input  logic [CHANNELS-1:0] a,
  input  logic                fault_clr,
  output logic [CHANNELS-1:0] o_oe,
  output logic [CHANNELS-1:0] o_p,
  output logic [CHANNELS-1:0] o_n,
  output logic [CHANNELS-1:0] busy,
  output logic                fault
);

  typedef enum logic [1:0] {
    OFF      = 2'd0,
    TURN_ON  = 2'd1,
    ON       = 2'd2,
    TURN_OFF = 2'd3
  } state_t;

  localparam logic [3:0] GUARD_M1 = (GUARD_CYCLES == 0) ? 4'd0 : 4'(GUARD_CYCLES - 1);

  logic [CHANNELS-1:0] data_d;
  logic [CHANNELS-1:0] viol;

  // Free-running delay pipe; the output register adds the final stage of latency.
  if (DELAY == 0) begin : g_nodly
    assign data_d = a;
  end else begin : g_dly
    logic [CHANNELS-1:0] dly [DELAY];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DELAY; i++) dly[i] <= '0;
      end else begin
        dly[0] <= a;
        for (int i = 1; i < DELAY; i++) dly[i] <= dly[i-1];
      end
    end

    assign data_d = dly[DELAY-1];
  end

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       oe_q, p_q, n_q;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
        OFF: begin
          if (en[ch]) begin
            if (GUARD_CYCLES == 0) begin
              state_d = ON;
            end else begin
              state_d = TURN_ON;
              cnt_d   = GUARD_M1;
            end
          end
        end
        TURN_ON: begin
          if (!en[ch]) begin
            state_d = TURN_OFF;
            cnt_d   = GUARD_M1;
          end else if (cnt_q == 4'd0) begin
            state_d = ON;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        ON: begin
          if (!en[ch]) begin
            if (GUARD_CYCLES == 0) begin
              state_d = OFF;
            end else begin
              state_d = TURN_OFF;
              cnt_d   = GUARD_M1;
            end
          end
        end
        TURN_OFF: begin
          // Turnaround always runs to completion so the bus sees a full idle gap.
          if (cnt_q == 4'd0) state_d = OFF;
          else               cnt_d   = cnt_q - 4'd1;
        end
        default: state_d = OFF;
      endcase
    end

    // Pad outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= OFF;
        cnt_q   <= 4'd0;
        oe_q    <= 1'b0;
        p_q     <= 1'b0;
        n_q     <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        oe_q    <= (state_d != OFF);
        p_q     <= (state_d == ON) && data_d[ch];
        n_q     <= (state_d == ON) ? ~data_d[ch] : (state_d != OFF);
      end
    end

    assign o_oe[ch] = oe_q;
    assign o_p[ch]  = p_q;
    assign o_n[ch]  = n_q;
    assign busy[ch] = (state_q == TURN_ON) || (state_q == TURN_OFF);
    assign viol[ch] = (state_q == TURN_OFF) && en[ch];
  end

  // A new violation outranks a clear arriving in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         fault <= 1'b0;
    else if (|viol)     fault <= 1'b1;
    else if (fault_clr) fault <= 1'b0;
  end

endmodule

// File: tb/tb_o_buft_ds_bank.sv
// Directed self-checking bench for o_buft_ds_bank using three parameterisations:
// A (GUARD=2, DELAY=0), B (GUARD=2, DELAY=2), C (GUARD=0, DELAY=0).
module tb_o_buft_ds_bank;

  logic clk;
  logic rst_n;

  logic [3:0] en_a, a_a, oe_a, p_a, n_a, busy_a;
  logic       clr_a, fault_a;
  logic [3:0] en_b, a_b, oe_b, p_b, n_b, busy_b;
  logic       clr_b, fault_b;
  logic [3:0] en_c, a_c, oe_c, p_c, n_c, busy_c;
  logic       clr_c, fault_c;

  int total;
  int passed;

  o_buft_ds_bank #(.CHANNELS(4), .GUARD_CYCLES(2), .DELAY(0)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .a(a_a), .fault_clr(clr_a),
    .o_oe(oe_a), .o_p(p_a), .o_n(n_a), .busy(busy_a), .fault(fault_a)
  );

  o_buft_ds_bank #(.CHANNELS(4), .GUARD_CYCLES(2), .DELAY(2)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .a(a_b), .fault_clr(clr_b),
    .o_oe(oe_b), .o_p(p_b), .o_n(n_b), .busy(busy_b), .fault(fault_b)
  );

  o_buft_ds_bank #(.CHANNELS(4), .GUARD_CYCLES(0), .DELAY(0)) u_c (
    .clk(clk), .rst_n(rst_n), .en(en_c), .a(a_c), .fault_clr(clr_c),
    .o_oe(oe_c), .o_p(p_c), .o_n(n_c), .busy(busy_c), .fault(fault_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [16:0] obs;
    rst_n = 1'b0;
    en_a = 4'hF; a_a = 4'hF;
    repeat (3) tick();
    obs = {oe_a, p_a, n_a, busy_a, fault_a};
    total++;
    if (obs !== 17'h0) $display("[TB] FAIL reset_hold: got %h expected %h", obs, 17'h0);
    else passed++;
    rst_n = 1'b1;
    tick();
    obs = {oe_a, p_a, n_a, busy_a, fault_a};
    total++;
    if (obs !== {4'hF, 4'h0, 4'hF, 4'hF, 1'b0})
      $display("[TB] FAIL reset_release: got %h expected %h", obs, {4'hF, 4'h0, 4'hF, 4'hF, 1'b0});
    else passed++;
    en_a = 4'h0; a_a = 4'h0;
    repeat (4) tick();
    obs = {oe_a, p_a, n_a, busy_a, fault_a};
    total++;
    if (obs !== 17'h0) $display("[TB] FAIL reset_abort_off: got %h expected %h", obs, 17'h0);
    else passed++;
  endtask

  task automatic test_turn_on();
    logic [3:0] obs;
    en_a = 4'b0001; a_a = 4'b0001;
    for (int c = 1; c <= 2; c++) begin
      tick();
      obs = {oe_a[0], p_a[0], n_a[0], busy_a[0]};
      total++;
      if (obs !== 4'b1011) $display("[TB] FAIL turn_on_guard%0d: got %b expected %b", c, obs, 4'b1011);
      else passed++;
    end
    tick();
    obs = {oe_a[0], p_a[0], n_a[0], busy_a[0]};
    total++;
    if (obs !== 4'b1100) $display("[TB] FAIL turn_on_data1: got %b expected %b", obs, 4'b1100);
    else passed++;
    a_a = 4'b0000;
    tick();
    obs = {oe_a[0], p_a[0], n_a[0], busy_a[0]};
    total++;
    if (obs !== 4'b1010) $display("[TB] FAIL turn_on_data0: got %b expected %b", obs, 4'b1010);
    else passed++;
    total++;
    if (oe_a[3:1] !== 3'b000) $display("[TB] FAIL turn_on_other_ch: got %b expected %b", oe_a[3:1], 3'b000);
    else passed++;
  endtask

  task automatic test_turn_off();
    logic [3:0] obs;
    a_a = 4'b0001;
    tick();
    en_a = 4'b0000;
    for (int c = 1; c <= 2; c++) begin
      tick();
      obs = {oe_a[0], p_a[0], n_a[0], busy_a[0]};
      total++;
      if (obs !== 4'b1011) $display("[TB] FAIL turn_off_guard%0d: got %b expected %b", c, obs, 4'b1011);
      else passed++;
    end
    tick();
    obs = {oe_a[0], p_a[0], n_a[0], busy_a[0]};
    total++;
    if (obs !== 4'b0000) $display("[TB] FAIL turn_off_done: got %b expected %b", obs, 4'b0000);
    else passed++;
  endtask

  task automatic test_data_latency();
    logic [11:0] pat;
    logic        exp_p;
    pat = 12'b1011_0010_1110;
    en_b = 4'b0001; a_b = 4'b0000;
    repeat (4) tick();
    for (int k = 0; k < 12; k++) begin
      a_b[0] = pat[k];
      tick();
      exp_p = (k >= 2) ? pat[k-2] : 1'b0;
      total++;
      if (p_b[0] !== exp_p || n_b[0] !== ~exp_p || oe_b[0] !== 1'b1)
        $display("[TB] FAIL data_latency_k%0d: got oe=%b p=%b n=%b expected oe=1 p=%b n=%b",
                 k, oe_b[0], p_b[0], n_b[0], exp_p, ~exp_p);
      else passed++;
    end
    en_b = 4'b0000;
    repeat (4) tick();
    total++;
    if (oe_b !== 4'h0) $display("[TB] FAIL data_latency_off: got %b expected %b", oe_b, 4'h0);
    else passed++;
  endtask

  task automatic test_fault();
    logic [4:0] obs;
    clr_a = 1'b0;
    total++;
    if (fault_a !== 1'b0) $display("[TB] FAIL fault_initial: got %b expected 0", fault_a);
    else passed++;
    en_a = 4'b0001; a_a = 4'b0001;
    repeat (3) tick();
    en_a = 4'b0000;
    tick();
    en_a = 4'b0001;
    tick();
    obs = {fault_a, oe_a[0], p_a[0], n_a[0], busy_a[0]};
    total++;
    if (obs !== 5'b11011) $display("[TB] FAIL fault_set: got %b expected %b", obs, 5'b11011);
    else passed++;
    tick();
    obs = {fault_a, oe_a[0], p_a[0], n_a[0], busy_a[0]};
    total++;
    if (obs !== 5'b10000) $display("[TB] FAIL fault_turnoff_completes: got %b expected %b", obs, 5'b10000);
    else passed++;
    tick();
    obs = {fault_a, oe_a[0], p_a[0], n_a[0], busy_a[0]};
    total++;
    if (obs !== 5'b11011) $display("[TB] FAIL fault_turnon_restart: got %b expected %b", obs, 5'b11011);
    else passed++;
    en_a = 4'b0000;
    tick();
    en_a = 4'b0001; clr_a = 1'b1;
    tick();
    total++;
    if (fault_a !== 1'b1) $display("[TB] FAIL fault_set_beats_clr: got %b expected 1", fault_a);
    else passed++;
    en_a = 4'b0000;
    tick();
    total++;
    if (fault_a !== 1'b0) $display("[TB] FAIL fault_clr_alone: got %b expected 0", fault_a);
    else passed++;
    clr_a = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_zero_guard();
    logic [16:0] obs;
    en_c = 4'b0101; a_c = 4'b1111;
    tick();
    obs = {oe_c, p_c, n_c, busy_c, fault_c};
    total++;
    if (obs !== {4'b0101, 4'b0101, 4'b0000, 4'b0000, 1'b0})
      $display("[TB] FAIL zero_guard_on: got %h expected %h", obs, {4'b0101, 4'b0101, 4'b0000, 4'b0000, 1'b0});
    else passed++;
    a_c = 4'b0000;
    tick();
    obs = {oe_c, p_c, n_c, busy_c, fault_c};
    total++;
    if (obs !== {4'b0101, 4'b0000, 4'b0101, 4'b0000, 1'b0})
      $display("[TB] FAIL zero_guard_data0: got %h expected %h", obs, {4'b0101, 4'b0000, 4'b0101, 4'b0000, 1'b0});
    else passed++;
    en_c = 4'b0000;
    tick();
    obs = {oe_c, p_c, n_c, busy_c, fault_c};
    total++;
    if (obs !== 17'h0) $display("[TB] FAIL zero_guard_off: got %h expected %h", obs, 17'h0);
    else passed++;
  endtask

  initial begin
    total = 0; passed = 0;
    rst_n = 1'b0;
    en_a = '0; a_a = '0; clr_a = 1'b0;
    en_b = '0; a_b = '0; clr_b = 1'b0;
    en_c = '0; a_c = '0; clr_c = 1'b0;
    test_reset();
    test_turn_on();
    test_turn_off();
    test_data_latency();
    test_fault();
    test_zero_guard();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
